// File: rtl/iic_wrbyte_if.sv
// Signal bundle between the IIC sequencer and the byte transmitter iic_wrbyte.
// state_dbg mirrors the transmitter FSM state for checkers and debug.
interface iic_wrbyte_if;
    // Handshake: start is a request that is honoured only while busy = 0; the
    // byte on tx_data is captured on that same clk edge. There is no separate
    // ready: busy = 1 means "not ready", and any start seen then is dropped.
    // done / arb_err are single-clk completion / abort pulses.
    logic       start;
    logic [7:0] tx_data;
    logic       scl_lc;
    logic       scl_hc;
    logic       scl_ls;
    logic       sda_in;
    logic       sda_out;
    logic       sda_oe;
    logic       busy;
    logic       done;
    logic       arb_err;
    logic [1:0] state_dbg;

    modport master (
        output start, tx_data, scl_lc, scl_hc, scl_ls, sda_in,
        input  sda_out, sda_oe, busy, done, arb_err, state_dbg
    );

    modport slave (
        input  start, tx_data, scl_lc, scl_hc, scl_ls, sda_in,
        output sda_out, sda_oe, busy, done, arb_err, state_dbg
    );
endinterface

// File: rtl/iic_wrbyte.sv
// SHT21 IIC byte transmitter: shifts one byte MSB-first onto SDA on SCL strobes.
// Optional SDA readback/arbitration check is enabled by IIC_WRBYTE_ARB_CHECK_EN.
module iic_wrbyte #(
    parameter int NBITS = 8
) (
    input logic        clk,
    input logic        rst,
    iic_wrbyte_if.slave bus
);
    localparam int CW = $clog2(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t           state;
    logic [NBITS-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             sda_out_q;
    logic             sda_oe_q;
    logic             busy_q;
    logic             done_q;
`ifdef IIC_WRBYTE_ARB_CHECK_EN
    logic             arb_err_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            sda_out_q <= 1'b1;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef IIC_WRBYTE_ARB_CHECK_EN
            arb_err_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef IIC_WRBYTE_ARB_CHECK_EN
            arb_err_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        shreg  <= bus.tx_data;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ALIGN;
                    end
                end
                // Only a low-centre strobe may start the first bit, so SDA
                // never changes while SCL is high.
                ALIGN: begin
                    if (bus.scl_lc) begin
                        sda_oe_q  <= 1'b1;
                        sda_out_q <= shreg[NBITS-1];
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
`ifdef IIC_WRBYTE_ARB_CHECK_EN
                    if (bus.scl_hc) begin
                        // Another master pulled SDA low: back off at once.
                        if (sda_oe_q && (bus.sda_in != sda_out_q)) begin
                            arb_err_q <= 1'b1;
                            sda_oe_q  <= 1'b0;
                            sda_out_q <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end
                    end else
`endif
                    if (bus.scl_ls) begin
                        if (cnt == LAST) begin
                            sda_oe_q  <= 1'b0;
                            sda_out_q <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            shreg <= {shreg[NBITS-2:0], 1'b0};
                            cnt   <= cnt + 1'b1;
                        end
                    end else if (bus.scl_lc) begin
                        sda_out_q <= shreg[NBITS-1];
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.sda_out   = sda_out_q;
    assign bus.sda_oe    = sda_oe_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.state_dbg = state;
`ifdef IIC_WRBYTE_ARB_CHECK_EN
    assign bus.arb_err   = arb_err_q;
`else
    assign bus.arb_err   = 1'b0;
`endif
endmodule

// File: tb/tb_iic_wrbyte.sv
// Bench for iic_wrbyte: directed scenarios plus random bytes/periods, checked
// against the MSB-first bit sequence of each byte and pulse counts.
module tb_iic_wrbyte;
    logic clk = 1'b0;
    logic rst;
    logic force_low = 1'b0;

    always #5 clk = ~clk;

    iic_wrbyte_if bus ();

    iic_wrbyte #(.NBITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Open-drain bus: released SDA reads 1 unless another master pulls it low.
    assign bus.sda_in = force_low ? 1'b0 : (bus.sda_oe ? bus.sda_out : 1'b1);

    int   errors      = 0;
    int   checks      = 0;
    int   done_cycles = 0;
    int   arb_cycles  = 0;
    int   exp_done    = 0;
    int   exp_arb     = 0;
    logic exp_q[$];

    always @(negedge clk) begin
        if (bus.done)    done_cycles++;
        if (bus.arb_err) arb_cycles++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 = scl_lc, 2 = scl_ls; returns one negedge after the strobe edge.
    task automatic strobe(input int which);
        @(negedge clk);
        if (which == 0) bus.scl_lc = 1'b1;
        else            bus.scl_ls = 1'b1;
        @(negedge clk);
        bus.scl_lc = 1'b0;
        bus.scl_ls = 1'b0;
    endtask

    task automatic begin_xfer(input logic [7:0] b, input bit now);
        if (!now) @(negedge clk);
        bus.start   = 1'b1;
        bus.tx_data = b;
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.tx_data = 8'($urandom);
        check("busy_rise", 32'(bus.busy), 1);
        check("align_released", 32'(bus.sda_oe), 0);
    endtask

    task automatic bit_period(input int p, input int i, input bit arb_hit, output bit aborted);
        logic e;
        aborted = 1'b0;
        strobe(0);
        check("lc_drive_oe", 32'(bus.sda_oe), 1);
        idle(p / 2 - 2);
        @(negedge clk);
        bus.scl_hc = 1'b1;
        force_low  = arb_hit;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check($sformatf("bit%0d", i), 32'(bus.sda_out), 32'(e));
        @(negedge clk);
        bus.scl_hc = 1'b0;
        force_low  = 1'b0;
`ifdef IIC_WRBYTE_ARB_CHECK_EN
        if (arb_hit) begin
            exp_arb++;
            check("arb_err_pulse", 32'(bus.arb_err), 1);
            check("arb_release_oe", 32'(bus.sda_oe), 0);
            check("arb_release_out", 32'(bus.sda_out), 1);
            check("arb_busy_low", 32'(bus.busy), 0);
            @(negedge clk);
            check("arb_err_one_clk", 32'(bus.arb_err), 0);
            exp_q.delete();
            aborted = 1'b1;
            return;
        end
`endif
        check("arb_quiet", 32'(bus.arb_err), 0);
        idle(p / 4 - 2);
        strobe(2);
        if (i < 7) begin
            check("mid_busy", 32'(bus.busy), 1);
            check("mid_oe", 32'(bus.sda_oe), 1);
            idle(p / 4 - 2);
        end else begin
            exp_done++;
            check("done_pulse", 32'(bus.done), 1);
            check("done_busy_low", 32'(bus.busy), 0);
            check("done_oe_low", 32'(bus.sda_oe), 0);
            check("done_out_high", 32'(bus.sda_out), 1);
        end
    endtask

    task automatic run_byte(input int p, input int arb_bit, input bit mid_start);
        bit ab;
        for (int i = 0; i < 8; i++) begin
            if (mid_start && i == 3) begin
                @(negedge clk);
                bus.start   = 1'b1;
                bus.tx_data = 8'hFF;
                @(negedge clk);
                bus.start   = 1'b0;
                check("mid_start_busy", 32'(bus.busy), 1);
            end
            bit_period(p, i, (i == arb_bit), ab);
            if (ab) break;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b2b;
        bit ab;
        bus.start   = 1'b0;
        bus.tx_data = 8'h00;
        bus.scl_lc  = 1'b0;
        bus.scl_hc  = 1'b0;
        bus.scl_ls  = 1'b0;
        rst = 1'b1;
        idle(3);
        check("rst_sda_out", 32'(bus.sda_out), 1);
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_arb_err", 32'(bus.arb_err), 0);
        rst = 1'b0;
        idle(2);

        // 0xA5 at the nominal 250-clk SCL period, then 0x81 back-to-back.
        begin_xfer(8'hA5, 1'b0);
        run_byte(250, -1, 1'b0);
        begin_xfer(8'h81, 1'b1);
        run_byte(40, -1, 1'b0);
        idle(4);

        // High-centre and falling-edge strobes before the first low-centre.
        begin_xfer(8'h80, 1'b0);
        @(negedge clk);
        bus.scl_hc = 1'b1;
        @(negedge clk);
        bus.scl_hc = 1'b0;
        check("stray_hc_oe", 32'(bus.sda_oe), 0);
        check("stray_hc_out", 32'(bus.sda_out), 1);
        check("stray_hc_busy", 32'(bus.busy), 1);
        idle(3);
        strobe(2);
        check("stray_ls_oe", 32'(bus.sda_oe), 0);
        run_byte(16, -1, 1'b0);
        idle(4);

        // A start during a transfer must not re-capture tx_data.
        begin_xfer(8'h40, 1'b0);
        run_byte(20, -1, 1'b1);
        idle(4);
        check("mid_start_done_count", 32'(done_cycles), 32'(exp_done));

        // Reset asserted between clock edges during the 4th bit.
        begin_xfer(8'h5A, 1'b0);
        for (int i = 0; i < 3; i++) bit_period(20, i, 1'b0, ab);
        strobe(0);
        idle(2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_oe", 32'(bus.sda_oe), 0);
        check("async_rst_out", 32'(bus.sda_out), 1);
        check("async_rst_busy", 32'(bus.busy), 0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        idle(4);
        check("post_rst_busy", 32'(bus.busy), 0);
        check("post_rst_no_done", 32'(done_cycles), 32'(exp_done));

        // Another master pulls SDA low at the 3rd sample point.
        begin_xfer(8'hFF, 1'b0);
        run_byte(16, 2, 1'b0);
        idle(4);
        check("arb_busy_after", 32'(bus.busy), 0);

        // Random bytes, random SCL periods, random back-to-back starts.
        b2b = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (!b2b) idle($urandom_range(1, 6));
            begin_xfer(8'($urandom), b2b);
            run_byte($urandom_range(12, 40), -1, 1'b0);
            b2b = 1'($urandom_range(0, 1));
        end
        idle(6);

        check("done_count", 32'(done_cycles), 32'(exp_done));
        check("arb_count", 32'(arb_cycles), 32'(exp_arb));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
